// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shared shift-add / restoring-divide
// datapath retiring one bit per cycle, with valid/ready on both sides.
module mul_div_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            operator_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]       acc_q, acc_d;
  logic [W-1:0]         b_q, b_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [W-1:0]         result_q, result_d;

  logic         is_div, signed_a, signed_b, sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;
  logic         div_zero, div_ovf;

  always_comb begin
    is_div   = operator_i[2];
    signed_a = (operator_i == OP_MULH) || (operator_i == OP_MULHSU) ||
               (operator_i == OP_DIV)  || (operator_i == OP_REM);
    signed_b = (operator_i == OP_MULH) || (operator_i == OP_DIV) || (operator_i == OP_REM);
    sign_a   = signed_a && operand_a_i[W-1];
    sign_b   = signed_b && operand_b_i[W-1];
    mag_a    = sign_a ? -operand_a_i : operand_a_i;
    mag_b    = sign_b ? -operand_b_i : operand_b_i;
    div_zero = is_div && (operand_b_i == '0);
    div_ovf  = ((operator_i == OP_DIV) || (operator_i == OP_REM)) &&
               (operand_a_i == MIN_NEG) && (operand_b_i == ALL_ONES);
  end

  // Multiply keeps the multiplier in acc low and adds into acc high; divide
  // shifts the dividend out of acc low while acc high holds the remainder.
  logic [W:0]     add_sum, sub_diff;
  logic [2*W-1:0] mul_step, div_step, prod;
  logic [W-1:0]   quo, rem;

  always_comb begin
    add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_step = {add_sum, acc_q[W-1:1]};
    sub_diff = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, b_q};
    div_step = sub_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                           : {sub_diff[W-1:0], acc_q[W-2:0], 1'b1};
    prod     = neg_q ? -acc_q : acc_q;
    quo      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem      = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          op_d = operator_i;
          if (div_zero) begin
            result_d = operator_i[1] ? operand_a_i : ALL_ONES;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = operator_i[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            acc_d   = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
            b_d     = is_div ? mag_b : mag_a;
            neg_d   = sign_a ^ sign_b;
            rneg_d  = sign_a;
            cnt_d   = CNT_WIDTH'(W - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        if (op_q[2])               result_d = op_q[1] ? rem : quo;
        else if (op_q == OP_MUL)   result_d = prod[W-1:0];
        else                       result_d = prod[2*W-1:W];
        state_d = DONE;
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV32M cases plus random operations checked
// against a plain-arithmetic reference model, with flush, stall and reset cases.
module tb_mul_div_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         flush_i = 1'b0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [2:0]   operator_i = 3'd0;
  logic [W-1:0] operand_a_i = '0;
  logic [W-1:0] operand_b_i = '0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [W-1:0] result_o;

  int checks = 0;
  int passed = 0;

  mul_div_unit #(.DATA_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .operator_i(operator_i), .operand_a_i(operand_a_i),
    .operand_b_i(operand_b_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // RISC-V M-extension results from 64-bit integer arithmetic
  function automatic logic [W-1:0] refModel(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int qa, qb;
    sa = 64'(longint'($signed(a)));
    sb = 64'(longint'($signed(b)));
    ua = {32'd0, a};
    ub = {32'd0, b};
    qa = $signed(a);
    qb = $signed(b);
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == '0) return '1;
        if (a == MIN_NEG && b == '1) return MIN_NEG;
        return qa / qb;
      end
      3'd5: begin
        if (b == '0) return '1;
        return a / b;
      end
      3'd6: begin
        if (b == '0) return a;
        if (a == MIN_NEG && b == '1) return '0;
        return qa % qb;
      end
      default: begin
        if (b == '0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Launch one operation, scramble the operand inputs after the accept edge,
  // then wait for the result and check value and latency (edges after accept).
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    logic [W-1:0] expRes;
    logic special;
    int expLat;
    int lat;
    expRes  = refModel(op, a, b);
    special = op[2] && ((b == '0) || (!op[0] && a == MIN_NEG && b == '1));
    expLat  = special ? 0 : W + 1;
    @(negedge clk_i);
    valid_i = 1'b1; operator_i = op; operand_a_i = a; operand_b_i = b;
    @(negedge clk_i);
    valid_i = 1'b0; operand_a_i = $urandom; operand_b_i = $urandom; operator_i = 3'($urandom);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput($sformatf("op%0d latency", op), 32'(lat), 32'(expLat));
    checkOutput($sformatf("op%0d valid_o", op), 32'(valid_o), 32'd1);
    checkOutput($sformatf("op%0d a=%08h b=%08h result", op, a, b), result_o, expRes);
  endtask

  task automatic releaseResult();
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    checkOutput("ready_o after handover", 32'(ready_o), 32'd1);
    checkOutput("valid_o after handover", 32'(valid_o), 32'd0);
  endtask

  initial begin
    logic sawValid;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;
    int mode;

    repeat (2) @(negedge clk_i);
    checkOutput("reset ready_o", 32'(ready_o), 32'd1);
    checkOutput("reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("reset result_o", result_o, 32'd0);
    rst_ni = 1'b1;

    applyStimulus(3'd0, 32'd7, 32'd6);                       releaseResult();
    applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);       releaseResult();
    applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000);       releaseResult();
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);       releaseResult();
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2);               releaseResult();
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2);               releaseResult();
    applyStimulus(3'd5, 32'd100, 32'd7);                     releaseResult();
    applyStimulus(3'd7, 32'd100, 32'd7);                     releaseResult();
    applyStimulus(3'd5, 32'd5, 32'd0);                       releaseResult();
    applyStimulus(3'd6, 32'd5, 32'd0);                       releaseResult();
    applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);       releaseResult();
    applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);       releaseResult();

    // Back-pressure: result must hold while the consumer stalls
    applyStimulus(3'd5, 32'd100, 32'd7);
    repeat (10) begin
      @(negedge clk_i);
      checkOutput("stall result_o", result_o, refModel(3'd5, 32'd100, 32'd7));
      checkOutput("stall ready_o", 32'(ready_o), 32'd0);
      checkOutput("stall valid_o", 32'(valid_o), 32'd1);
    end
    releaseResult();

    // Flush mid-CALC, with a divide-by-zero offered in the same cycle
    @(negedge clk_i);
    valid_i = 1'b1; operator_i = 3'd0; operand_a_i = $urandom; operand_b_i = $urandom;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    checkOutput("busy during CALC", 32'(ready_o), 32'd0);
    flush_i = 1'b1; valid_i = 1'b1; operator_i = 3'd5; operand_b_i = '0;
    @(negedge clk_i);
    flush_i = 1'b0; valid_i = 1'b0;
    checkOutput("flush ready_o", 32'(ready_o), 32'd1);
    checkOutput("flush valid_o", 32'(valid_o), 32'd0);
    sawValid = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) sawValid = 1'b1;
    end
    checkOutput("no valid_o after flush", 32'(sawValid), 32'd0);
    checkOutput("idle after flush", 32'(ready_o), 32'd1);

    // Random operations, biased toward the divide corner cases
    for (int i = 0; i < 40; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = '0;
      else if (mode == 1) begin ra = MIN_NEG; rb = '1; end
      else if (mode == 2) rb = 32'($urandom_range(1, 15));
      else if (mode == 3) ra = 32'($urandom_range(0, 255));
      applyStimulus(rop, ra, rb);
      releaseResult();
    end

    // Asynchronous reset in the middle of a divide, away from any clock edge
    @(negedge clk_i);
    valid_i = 1'b1; operator_i = 3'd4; operand_a_i = $urandom; operand_b_i = 32'd3;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("async reset ready_o", 32'(ready_o), 32'd1);
    checkOutput("async reset valid_o", 32'(valid_o), 32'd0);
    checkOutput("async reset result_o", result_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(3'd0, 32'd12345, 32'd678);
    releaseResult();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
